// File: rtl/logic_16_serial.sv
// Bit-serial 16-bit bitwise logic unit (AND/OR/XOR/NOT a), one bit per clock,
// LSB first, with valid/ready request and response handshakes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_a, req_b        operands, captured on the accepting edge
//   req_op              00 AND, 01 OR, 10 XOR, 11 NOT a
//   rsp_valid/rsp_ready response handshake
//   rsp_out, rsp_any    registered result word and its OR-reduction
module logic_16_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_any
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             bit_r;
    logic             accept;
    logic             last;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign accept    = req_valid && req_ready;
    assign last      = (cnt == CW'(WIDTH - 1));

    // One result bit from the current LSBs of the operand shifters.
    always_comb begin
        bit_r = 1'b0;
        unique case (op_q)
            2'b00:   bit_r = a_sh[0] & b_sh[0];
            2'b01:   bit_r = a_sh[0] | b_sh[0];
            2'b10:   bit_r = a_sh[0] ^ b_sh[0];
            default: bit_r = ~a_sh[0];
        endcase
    end

    // Result enters at the MSB so after WIDTH shifts bit 0 lands at bit 0.
    assign res_nx = {bit_r, res_sh[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = BUSY;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            op_q    <= 2'b00;
            cnt     <= '0;
            rsp_out <= '0;
            rsp_any <= 1'b0;
        end else if (accept) begin
            a_sh    <= req_a;
            b_sh    <= req_b;
            op_q    <= req_op;
            res_sh  <= '0;
            cnt     <= '0;
            rsp_out <= '0;
            rsp_any <= 1'b0;
        end else if (state == BUSY) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_nx;
            cnt    <= cnt + 1'b1;
            if (last) begin
                rsp_out <= res_nx;
                rsp_any <= |res_nx;
            end
        end
    end

endmodule

// File: tb/tb_logic_16_serial.sv
// Scoreboard bench for logic_16_serial: expected results are queued at
// acceptance and compared when the response handshake is about to happen.
module tb_logic_16_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [1:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_out;
    logic        rsp_any;

    int total = 0;
    int bad = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    logic_16_serial #(.WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_out(rsp_out),
        .rsp_any(rsp_any)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Handshake happens at the next rising edge; compare just before it.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("rsp_out", {16'd0, rsp_out}, {16'd0, e[15:0]});
                chk("rsp_any", {31'd0, rsp_any}, {31'd0, e[16]});
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request; scramble inputs during BUSY; check 16-cycle latency.
    // With hold>0 the response is back-pressured and a new request is
    // presented with next_a/next_b/next_op while waiting.
    task automatic do_req(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input int hold,
                          input logic [15:0] next_a,
                          input logic [15:0] next_b,
                          input logic [1:0] next_op);
        logic [15:0] r;
        wait_ready();
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        if (hold > 0) rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        r = model(a, b, op);
        exp_q.push_back({|r, r});
        req_valid = 1'b0;
        repeat (15) begin
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            req_op = 2'($urandom);
            @(posedge clk);
            #1;
        end
        chk("lat_early", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {31'd0, rsp_valid}, 32'd1);
        if (hold > 0) begin
            req_valid = 1'b1;
            req_a = next_a;
            req_b = next_b;
            req_op = next_op;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("bp_ready", {31'd0, req_ready}, 32'd0);
                chk("bp_out", {16'd0, rsp_out}, {16'd0, r});
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_reready", {31'd0, req_ready}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            chk("idle_ready", {31'd0, req_ready}, 32'd1);
            chk("keep_out", {16'd0, rsp_out}, {16'd0, r});
        end
    endtask

    initial begin
        req_valid = 1'b1;
        req_a = 16'hFFFF;
        req_b = 16'hFFFF;
        req_op = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_out", {16'd0, rsp_out}, 32'd0);
        chk("rst_any", {31'd0, rsp_any}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        do_req(16'h0001, 16'h0002, 2'b01, 0, '0, '0, '0);
        do_req(16'h0000, 16'h0000, 2'b01, 0, '0, '0, '0);
        do_req(16'h00FF, 16'h0F0F, 2'b00, 0, '0, '0, '0);
        do_req(16'hFFFF, 16'hAAAA, 2'b10, 0, '0, '0, '0);
        do_req(16'h0000, 16'h1234, 2'b11, 0, '0, '0, '0);
        do_req(16'h8000, 16'h0001, 2'b01, 0, '0, '0, '0);

        // Back-pressure; the pending request is accepted right after.
        do_req(16'h1234, 16'h00F0, 2'b10, 5, 16'hC3C3, 16'h0FF0, 2'b00);
        do_req(16'hC3C3, 16'h0FF0, 2'b00, 0, '0, '0, '0);

        // Abort mid-BUSY; no response may appear for it.
        wait_ready();
        req_valid = 1'b1;
        req_a = 16'hFFFF;
        req_b = 16'h0000;
        req_op = 2'b01;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_out", {16'd0, rsp_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_noresp", {31'd0, rsp_valid}, 32'd0);
        do_req(16'hF0F0, 16'hFF00, 2'b00, 0, '0, '0, '0);

        for (int i = 0; i < 6; i++) begin
            do_req(16'($urandom), 16'($urandom), 2'($urandom), 0,
                   '0, '0, '0);
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
